ram_arbiter_2port: RTL

Two-requester controller for the 16x8 asynchronous RAM (chip select, write enable, address, bidirectional data bus). Arbitrates round-robin between two clients, latches each granted request, and sequences the RAM pins through a fixed setup/transfer/recover cycle. Each client gets a one-cycle acknowledge and, for reads, registered read data. Sits between the RAM macro and client logic; it is the only driver of the RAM pins.

---
 rtl/ram_arbiter_2port.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ram_arbiter_2port.sv
// Round-robin two-client controller for a 16x8 asynchronous RAM.
// Every access runs SETUP -> XFER -> RECOVER; arbitration happens in IDLE and RECOVER.

module ram_arbiter_client #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  capture,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] bus,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata
);
  // Only the owning client's register ever loads; the other holds its last read.
  always_ff @(posedge clk) begin
    if (rst)                 rdata <= '0;
    else if (sel && capture) rdata <= bus;
  end

  assign ack = sel && done;
endmodule

module ram_arbiter_2port #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);
  localparam int NUM_CLIENTS = 2;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, RECOVER} state_t;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } op_t;

  state_t                                 state, next_state;
  op_t                                    op_q;
  op_t    [NUM_CLIENTS-1:0]               cand;
  logic   [NUM_CLIENTS-1:0]               req;
  logic   [NUM_CLIENTS-1:0]               ack;
  logic   [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] rdata;
  logic                                   owner;
  logic                                   grant;
  logic                                   take;
  logic                                   drive;
  logic                                   capture;
  logic                                   done;

  assign req     = {req1, req0};
  assign cand[0] = '{wr: wr0, addr: addr0, wdata: wdata0};
  assign cand[1] = '{wr: wr1, addr: addr1, wdata: wdata1};

  // owner doubles as the round-robin pointer: on a tie the other client wins.
  always_comb begin
    grant = owner;
    if (req[0] && req[1]) grant = ~owner;
    else if (req[0])      grant = 1'b0;
    else if (req[1])      grant = 1'b1;
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          next_state = SETUP;
          take       = 1'b1;
        end
      end
      SETUP:   next_state = XFER;
      XFER:    next_state = RECOVER;
      RECOVER: begin
        if (|req) begin
          next_state = SETUP;
          take       = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      owner <= 1'b1;
    end else begin
      state <= next_state;
      if (take) begin
        op_q  <= cand[grant];
        owner <= grant;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign ram_cs   = (state != IDLE);
  assign ram_we   = (state == XFER) && op_q.wr;
  assign ram_addr = op_q.addr;
  // Write data stays on the bus through RECOVER to cover the RAM hold time.
  assign drive    = op_q.wr && ((state == XFER) || (state == RECOVER));
  assign ram_data = drive ? op_q.wdata : {DATA_WIDTH{1'bz}};
  assign capture  = (state == XFER) && !op_q.wr;
  assign done     = (state == RECOVER);

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
    localparam logic ID = 1'(i);
    ram_arbiter_client #(.DATA_WIDTH(DATA_WIDTH)) u_client (
      .clk     (clk),
      .rst     (rst),
      .sel     (owner == ID),
      .capture (capture),
      .done    (done),
      .bus     (ram_data),
      .ack     (ack[i]),
      .rdata   (rdata[i])
    );
  end

  assign ack0   = ack[0];
  assign ack1   = ack[1];
  assign rdata0 = rdata[0];
  assign rdata1 = rdata[1];
endmodule
